// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants: FSM state encoding, S-box size,
// key length and key-byte width used by the KSA and decrypt controllers.
package rc4_pkg;

  localparam int S_SIZE    = 256;
  localparam int KEY_BYTES = 3;
  localparam int KB_W      = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_key_sel.sv
// Key-byte mux: picks key byte k (0 = bits 7:0) from the 24-bit key.
// Ports: key[23:0], k[1:0] in; kbyte[7:0] out (0 for k=3).
module rc4_key_sel
  import rc4_pkg::*;
(
  input  logic [23:0]     key,
  input  logic [1:0]      k,
  output logic [KB_W-1:0] kbyte
);

  always_comb begin
    kbyte = '0;
    case (k)
      2'd0:    kbyte = key[7:0];
      2'd1:    kbyte = key[15:8];
      2'd2:    kbyte = key[23:16];
      default: kbyte = '0;
    endcase
  end

endmodule

// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-scheduling sequencer driving a 1-cycle-latency S memory port.
// Ports: clk, reset, start, secret_key in; busy, done, mem_* out; mem_rddata in.
module rc4_ksa_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wrdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_rddata
);

  localparam logic [1:0] K_LAST = 2'(KEY_BYTES - 1);

  state_t      state;
  state_t      state_n;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [1:0]  k;
  logic [7:0]  si;
  logic [7:0]  sj;
  logic [23:0] key;
  logic [7:0]  kbyte;

  rc4_key_sel u_key_sel (
    .key   (key),
    .k     (k),
    .kbyte (kbyte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      key   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            key <= secret_key;
            i   <= '0;
            j   <= '0;
            k   <= '0;
          end
        end
        INIT: i <= i + 8'd1;
        GET_I: begin
          si <= mem_rddata;
          j  <= j + mem_rddata + kbyte;
        end
        GET_J: sj <= mem_rddata;
        WR_J: begin
          if (i != 8'hFF) begin
            i <= i + 8'd1;
            k <= (k == K_LAST) ? 2'd0 : k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port is decoded from registered state only, so mem_rddata
  // never reaches mem_addr in the same cycle.
  always_comb begin
    state_n    = state;
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_wren   = 1'b0;
    case (state)
      IDLE: if (start) state_n = INIT;
      INIT: begin
        mem_addr   = i;
        mem_wrdata = i;
        mem_wren   = 1'b1;
        if (i == 8'hFF) state_n = RD_I;
      end
      RD_I: begin
        mem_addr = i;
        state_n  = GET_I;
      end
      GET_I: state_n = RD_J;
      RD_J: begin
        mem_addr = j;
        state_n  = GET_J;
      end
      GET_J: state_n = WR_I;
      WR_I: begin
        mem_addr   = i;
        mem_wrdata = sj;
        mem_wren   = 1'b1;
        state_n    = WR_J;
      end
      // WR_J last, so i==j leaves S[i] holding its own value.
      WR_J: begin
        mem_addr   = j;
        mem_wrdata = si;
        mem_wren   = 1'b1;
        state_n    = (i == 8'hFF) ? DONE : RD_I;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/rc4_ksa_ctrl.md
# rc4_ksa_ctrl

Single-clock sequencer for the RC4 key-scheduling phase. It owns the single port of the 256×8 S memory and initialises it to S[i]=i. It then runs the full 256-iteration shuffle, j = j + S[i] + key[i mod 3] followed by swap(S[i], S[j]), using a start/busy/done handshake. It sits between the top-level task controller and the S-memory instance, and replaces strobe-driven shuffle sequencing with one synchronous FSM.

## Interface
- KEY_BYTES, 3: number of key bytes cycled by i mod KEY_BYTES
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- start  in  1  level; sampled only in IDLE
- secret_key  in  24  key; latched when start is accepted
- busy  out  1  high in every non-IDLE state
- done  out  1  single-cycle pulse when S is fully scheduled
- mem_addr  out  8  S memory address
- mem_wrdata  out  8  S memory write data
- mem_wren  out  1  S memory write enable
- mem_rddata  in  8  S memory read data; valid the cycle after mem_addr is presented (1-cycle latency)

## Operation
- Reset values: busy=0, done=0, mem_wren=0, mem_addr=0, mem_wrdata=0. Internal i, j, si, sj and key register are all 0.
- IDLE: when start=1, latch secret_key, clear i, j and k, then go to INIT.
- INIT: for each cycle, drive addr=i, wrdata=i, wren=1, then i++. After writing i=255, i wraps to 0 and the FSM goes to RD_I.
- RD_I: addr=i, wren=0.
- GET_I: capture si<=mem_rddata. Set j <= j + mem_rddata + kbyte, mod 256. kbyte is key[7:0], key[15:8] or key[23:16] for k=0, 1, 2.
- RD_J: addr=j.
- GET_J: capture sj<=mem_rddata.
- WR_I: addr=i, wrdata=sj, wren=1.
- WR_J: addr=j, wrdata=si, wren=1.
  - If i==255, go to DONE.
  - Otherwise i++ and k=(k==2)?0:k+1, then go to RD_I.
- DONE: done=1 for one cycle, then go to IDLE.
- k tracks i mod 3 incrementally; no divider is used.
- All arithmetic is 8-bit and wraps.
- i==j: the same address is written twice, with WR_J last and value si, so S[i] is unchanged (a self-swap).
- start while busy is ignored.
- start still high in IDLE after DONE: a new run begins, which makes the input level-sensitive by design.
- reset mid-run: the FSM returns to IDLE the next cycle with wren=0. S contents are left partially shuffled, and a new start re-initialises them.

## Timing
- Start sampled at edge 0. INIT writes occupy cycles 1–256.
- The shuffle takes 6 cycles per iteration, in the order RD_I, GET_I, RD_J, GET_J, WR_I, WR_J. It occupies cycles 257–1792.
- DONE is cycle 1793. busy is high for cycles 1–1793 and done only in cycle 1793.
- Exactly one memory access occurs per cycle. Reads never overlap writes.
- All outputs are registered, or decoded from registered state, with no combinational path from mem_rddata to mem_addr in the same cycle. The j update in GET_I is registered.

## Structure
- Package rc4_pkg holds:
  - the state enum {IDLE, INIT, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE}
  - S_SIZE=256
  - KEY_BYTES=3
  - the key-byte width
- One sub-module, rc4_key_sel: a combinational mux that takes the 24-bit key and k[1:0] and outputs an 8-bit kbyte. It is shared with the later decrypt controller.
- The FSM, counters and the memory-port drive live in rc4_ksa_ctrl.

## Test plan
- Reset and idle: assert reset for 3 cycles. All outputs must be 0. With start=0 for 20 cycles, no write may occur and busy must stay 0.
- Init phase: key 24'h000000, then pulse start. Cycles 1–256 must show wren=1 with addr=wrdata=0..255 in order. The memory model must then hold S[i]=i.
- First swap: key 24'h0000FF.
  - i=0 gives j=0xFF.
  - WR_I writes addr 0x00, data 0xFF.
  - WR_J writes addr 0xFF, data 0x00.
  - i=1 then uses kbyte=key[15:8]=0x00.
- Self-swap: key 24'h000000, i=0 gives j=0. Both writes go to addr 0 with data 0, and S[0] stays 0.
- Full run: key 24'h000249 against a software RC4-KSA model (byte order as in rc4_key_sel). Final S must match all 256 entries, done must pulse exactly at cycle 1793, and busy must be high for 1793 cycles. The check runs twice, the second time with start re-pulsed to confirm a clean restart.
- Robustness:
  - Toggling start during shuffle must not change the write sequence.
  - Asserting reset at cycle 900 must give busy=0 and wren=0 the next cycle.
  - A subsequent start must reproduce the same final S as an uninterrupted run.
